// File: rtl/set_pkg.sv
// Shared types and constants for the set grid-counting block.
// Optional build macro: SET_ROW_PARALLEL_EN.
package set_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [1:0] MODE_A   = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_TWO = 2'b11;

  localparam logic [3:0] GRID_MIN = 4'd1;
  localparam logic [3:0] GRID_MAX = 4'd8;

  localparam int CNT_W = 8;

  function automatic logic set_sel(
    input logic [1:0] m,
    input logic       a,
    input logic       b,
    input logic       c
  );
    logic [1:0] n;
    logic       r;
    n = {1'b0, a} + {1'b0, b} + {1'b0, c};
    r = 1'b0;
    unique case (1'b1)
      (m == MODE_A):   r = a;
      (m == MODE_AND): r = a & b;
      (m == MODE_XOR): r = a ^ b;
      (m == MODE_TWO): r = (n == 2'd2);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/set_in_circle.sv
// Combinational test: (px-cx)^2 + (py-cy)^2 <= r^2, boundary inside.
// Used 3x in the serial build, 24x with SET_ROW_PARALLEL_EN.
module set_in_circle (
  input  logic [3:0] px,
  input  logic [3:0] py,
  input  logic [3:0] cx,
  input  logic [3:0] cy,
  input  logic [3:0] r,
  output logic       in
);

  logic signed [4:0] dx;
  logic signed [4:0] dy;
  logic [3:0] ax;
  logic [3:0] ay;
  logic [7:0] sx;
  logic [7:0] sy;
  logic [8:0] sq;
  logic [7:0] r2;

  assign dx = $signed({1'b0, px}) - $signed({1'b0, cx});
  assign dy = $signed({1'b0, py}) - $signed({1'b0, cy});

  // |d| is at most 15, so the magnitude fits 4 bits
  assign ax = dx[4] ? 4'(-dx) : dx[3:0];
  assign ay = dy[4] ? 4'(-dy) : dy[3:0];

  assign sx = {4'b0, ax} * {4'b0, ax};
  assign sy = {4'b0, ay} * {4'b0, ay};
  assign sq = {1'b0, sx} + {1'b0, sy};
  assign r2 = {4'b0, r} * {4'b0, r};

  assign in = (sq <= {1'b0, r2});

endmodule

// File: rtl/set.sv
// Set-counting accelerator over the 8x8 grid for three circles.
// Optional build macro: SET_ROW_PARALLEL_EN (one row per cycle).
module set
  import set_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] central,
  input  logic [11:0] radius,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic        valid,
  output logic [7:0]  candidate
);

  state_t st;
  state_t st_nx;

  logic [23:0] cen_q;
  logic [11:0] rad_q;
  logic [1:0]  mode_q;
  logic [3:0]  py;
  logic [3:0]  hits;
  logic [3:0]  hit_q;
  logic [CNT_W-1:0] acc;
  logic        fin_q;
  logic        at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    if (en) st_nx = CALC;
      CALC:    if (fin_q) st_nx = DONE;
      DONE:    st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  assign busy  = (st != IDLE);
  assign valid = (st == DONE);

`ifdef SET_ROW_PARALLEL_EN

  logic [7:0] row_hit;

  assign at_last = (py == GRID_MAX);

  for (genvar i = 0; i < 8; i++) begin : g_col
    localparam logic [3:0] X = 4'(i + 1);
    logic in_a;
    logic in_b;
    logic in_c;

    set_in_circle u_a (
      .px(X), .py(py),
      .cx(cen_q[23:20]), .cy(cen_q[19:16]),
      .r(rad_q[11:8]), .in(in_a)
    );
    set_in_circle u_b (
      .px(X), .py(py),
      .cx(cen_q[15:12]), .cy(cen_q[11:8]),
      .r(rad_q[7:4]), .in(in_b)
    );
    set_in_circle u_c (
      .px(X), .py(py),
      .cx(cen_q[7:4]), .cy(cen_q[3:0]),
      .r(rad_q[3:0]), .in(in_c)
    );

    assign row_hit[i] = set_sel(mode_q, in_a, in_b, in_c);
  end

  always_comb begin
    hits = '0;
    for (int k = 0; k < 8; k++) begin
      hits = hits + {3'b0, row_hit[k]};
    end
  end

`else

  logic [3:0] px;
  logic in_a;
  logic in_b;
  logic in_c;

  assign at_last = (px == GRID_MAX) && (py == GRID_MAX);

  set_in_circle u_a (
    .px(px), .py(py),
    .cx(cen_q[23:20]), .cy(cen_q[19:16]),
    .r(rad_q[11:8]), .in(in_a)
  );
  set_in_circle u_b (
    .px(px), .py(py),
    .cx(cen_q[15:12]), .cy(cen_q[11:8]),
    .r(rad_q[7:4]), .in(in_b)
  );
  set_in_circle u_c (
    .px(px), .py(py),
    .cx(cen_q[7:4]), .cy(cen_q[3:0]),
    .r(rad_q[3:0]), .in(in_c)
  );

  assign hits = {3'b0, set_sel(mode_q, in_a, in_b, in_c)};

`endif

  // Hits are registered one cycle before being summed, so the
  // final add happens on the CALC->DONE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cen_q     <= '0;
      rad_q     <= '0;
      mode_q    <= '0;
      py        <= GRID_MIN;
`ifndef SET_ROW_PARALLEL_EN
      px        <= GRID_MIN;
`endif
      hit_q     <= '0;
      acc       <= '0;
      fin_q     <= 1'b0;
      candidate <= '0;
    end else if (st == IDLE && en) begin
      cen_q  <= central;
      rad_q  <= radius;
      mode_q <= mode;
      py     <= GRID_MIN;
`ifndef SET_ROW_PARALLEL_EN
      px     <= GRID_MIN;
`endif
      hit_q  <= '0;
      acc    <= '0;
      fin_q  <= 1'b0;
    end else if (st == CALC) begin
      if (fin_q) begin
        candidate <= acc + {4'b0, hit_q};
      end else begin
        hit_q <= hits;
        acc   <= acc + {4'b0, hit_q};
        fin_q <= at_last;
`ifdef SET_ROW_PARALLEL_EN
        py <= py + 4'd1;
`else
        if (px == GRID_MAX) begin
          px <= GRID_MIN;
          py <= py + 4'd1;
        end else begin
          px <= px + 4'd1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_set.sv
// Directed-vector bench for the set grid-counting block.
// Honours SET_ROW_PARALLEL_EN for the expected latency.
module tb_set;

`ifdef SET_ROW_PARALLEL_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 65;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic        busy;
  logic        valid;
  logic [7:0]  candidate;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    int          exp;
  } vec_t;

  vec_t vt[13];

  set dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .central(central),
    .radius(radius),
    .mode(mode),
    .busy(busy),
    .valid(valid),
    .candidate(candidate)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic start_job(input vec_t v, input string nm);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({nm, " idle before start"}, int'(busy), 0);
    central = v.central;
    radius  = v.radius;
    mode    = v.mode;
    en      = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    check({nm, " busy after accept"}, int'(busy), 1);
  endtask

  task automatic finish_job(input int exp, input int elapsed, input string nm);
    int c;
    c = elapsed;
    while (!valid && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    check({nm, " latency"}, c, LAT);
    check({nm, " candidate"}, int'(candidate), exp);
    check({nm, " busy with valid"}, int'(busy), 1);
    @(posedge clk);
    #1;
    check({nm, " valid one cycle"}, int'(valid), 0);
    check({nm, " busy fall"}, int'(busy), 0);
  endtask

  task automatic run_job(input vec_t v, input string nm);
    start_job(v, nm);
    finish_job(v.exp, 0, nm);
  endtask

  initial begin
    int seen;
    vt[0]  = '{24'h444400, 12'h200, 2'b00, 13};
    vt[1]  = '{24'h110000, 12'h100, 2'b00, 3};
    vt[2]  = '{24'h330000, 12'h000, 2'b00, 1};
    vt[3]  = '{24'h440000, 12'hF00, 2'b00, 64};
    vt[4]  = '{24'h444400, 12'h220, 2'b01, 13};
    vt[5]  = '{24'h444400, 12'h220, 2'b10, 0};
    vt[6]  = '{24'h227700, 12'h110, 2'b01, 0};
    vt[7]  = '{24'h227700, 12'h110, 2'b10, 10};
    vt[8]  = '{24'h444488, 12'h220, 2'b11, 13};
    vt[9]  = '{24'h444444, 12'h222, 2'b11, 0};
    vt[10] = '{24'h000000, 12'h200, 2'b00, 1};
    vt[11] = '{24'h990000, 12'h200, 2'b00, 1};
    vt[12] = '{24'h222388, 12'h110, 2'b11, 2};

    rst     = 1'b1;
    en      = 1'b0;
    central = '0;
    radius  = '0;
    mode    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset valid", int'(valid), 0);
    check("reset candidate", int'(candidate), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // back-to-back: each job starts as soon as busy drops
    for (int i = 0; i < 13; i++) begin
      run_job(vt[i], $sformatf("vec%0d", i));
    end

    // en and input changes while busy must be ignored
    start_job(vt[0], "ignore");
    repeat (3) @(posedge clk);
    #1;
    en      = 1'b1;
    central = 24'h110000;
    radius  = 12'hF00;
    mode    = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    en = 1'b0;
    finish_job(13, 6, "ignore");
    seen = 0;
    repeat (LAT + 5) begin
      @(posedge clk);
      #1;
      if (busy || valid) seen++;
    end
    check("ignore no extra job", seen, 0);

    // reset in the middle of CALC aborts the job
    start_job(vt[3], "abort");
    repeat (LAT / 2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort valid", int'(valid), 0);
    check("abort candidate", int'(candidate), 0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    repeat (LAT + 10) begin
      @(posedge clk);
      #1;
      if (valid) seen++;
    end
    check("abort no strobe", seen, 0);

    run_job(vt[7], "recover");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/set.md
# set

Geometric set-counting block for an 8×8 integer grid. Each job supplies three circles A, B and C and a mode. The block counts the grid points (x, y ∈ 1..8) that satisfy the selected set expression and returns the count with a one-cycle valid strobe. It is a standalone accelerator with a busy/en request handshake.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  job request; sampled only when busy=0.
- central  in  24  {xA, yA, xB, yB, xC, yC}, 4 bits each, MSB first.
- radius  in  12  {rA, rB, rC}, 4 bits each, MSB first.
- mode  in  2  set expression select; latched with en.
- busy  out  1  high while a job is in progress.
- valid  out  1  one-cycle result strobe.
- candidate  out  8  point count, 0..64.

## Operation
- A point P is in circle K when (Px−xK)² + (Py−yK)² ≤ rK². The boundary counts as inside.
- Arithmetic width rules:
  - Differences are 5-bit signed.
  - Squares and sums are held in 9 bits; the sum is at most 450.
  - rK² is held in 8 bits.
  - All 4-bit centre and radius values are legal, including 0 and 9..15.
- Mode encodings:
  - 00: A.
  - 01: A∩B.
  - 10: A⊕B, i.e. (A∪B)−(A∩B).
  - 11: points in exactly two of A, B and C.
- FSM states:
  - IDLE: busy=0. When en=1, latch central, radius and mode, clear the accumulator, set the point index to (1,1), and go to CALC.
  - CALC: busy=1. Evaluate one point per cycle in row-major order (x inner loop) and add 1 when the point satisfies the expression. After point (8,8), go to DONE.
  - DONE: busy=1 and valid=1 for exactly one cycle. candidate = final count. Go to IDLE.
- candidate holds its value after DONE until the next job reaches DONE.
- en while busy=1 is ignored. Input changes after the latch edge have no effect.
- Reset values: busy=0, valid=0, candidate=0, state IDLE.
- Reset mid-job aborts the job with no valid pulse.

## Timing
- Edge E samples en=1. busy is high from E.
- CALC occupies edges E+1..E+64.
- valid is high during the cycle after edge E+65, so the en-to-valid latency is 65 cycles.
- busy falls at edge E+66.
- A new en may be accepted at edge E+66 or any later edge.
- Throughput: one job per 66 cycles.
- There is no combinational path from inputs to outputs.

## Configuration
- SET_ROW_PARALLEL_EN:
  - When defined, CALC evaluates one full row (8 points) per cycle using 24 comparators and an adder tree. CALC lasts 8 cycles, latency is 9 cycles, and busy falls at E+10.
  - When undefined, the block evaluates one point per cycle with 3 comparators, as specified above.
- Counts are identical in both builds.

## Structure
- Package set_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the mode constants (MODE_A, MODE_AND, MODE_XOR, MODE_TWO);
  - GRID_MIN=1, GRID_MAX=8;
  - the count width of 8.
- Sub-module set_in_circle: combinational point-in-circle test with inputs px, py, cx, cy, r and output in. It is instantiated 3 times, or 24 times with SET_ROW_PARALLEL_EN.

## Test plan
- Mode 00, A=(4,4) rA=2 (central=0x44xxxx, radius=0x2xx) -> candidate=13; valid is one cycle, 65 cycles after en.
- Mode 00 edge cases:
  - A=(1,1) rA=1 -> 3.
  - A=(3,3) rA=0 -> 1.
  - A=(4,4) rA=15 -> 64.
- Modes 01 and 10 with A=B=(4,4) r=2 -> 13 and 0 respectively.
- Modes 01 and 10 with A=(2,2) r=1 and B=(7,7) r=1 -> 0 and 10 respectively.
- Mode 11:
  - A=B=(4,4) r=2, C=(8,8) r=0 -> 13.
  - All three circles identical -> 0.
- Handshake and reset:
  - en pulsed while busy is ignored; the result is unchanged.
  - rst asserted mid-CALC -> busy, valid and candidate all 0, with no strobe.
  - Back-to-back jobs accepted as soon as busy falls.
